repairval_partner_responder: RTL and testbench
==============================================

// Module: repairval_partner_responder
// PURPOSE
//  Partner-side (responder) half of the MBINIT.REPAIRVAL sideband handshake. Answers the remote initiator's
//  init/result/done requests with init/result/done responses. Between init and result it enables the
//  valid-lane receive comparator and accumulates a per-sample pass/fail window into a logged result.
//  Sits in LTSM/MBINIT beside the initiator FSM and shares the sideband TX arbiter and RX decoder with it.
// PARAMETERS
//  PATTERN_LEN   128    valid-lane samples expected per pattern burst
//  ERR_THRESH    0      max mismatching samples still reported as pass
//  TIMEOUT_CYC   8000   cycles allowed in any WAIT_* state before a train error
// PORTS
//  CLK                 in   1  block clock
//  rst                 in   1  asynchronous, active-high reset
//  i_REPAIRVAL_en      in   1  level; MBINIT is in REPAIRVAL; low forces IDLE from any state
//  i_Rx_SbMessage      in   4  decoded RX sideband message (1 init_req,2 init_resp,3 result_req,4 result_resp,5 done_req,6 done_resp)
//  i_msg_valid         in   1  i_Rx_SbMessage valid this cycle (1-cycle pulse)
//  i_Busy_SideBand     in   1  sideband TX busy
//  i_falling_edge_busy in   1  1-cycle pulse: TX finished the last message
//  i_val_sample_valid  in   1  comparator produced one valid-lane sample
//  i_val_sample_match  in   1  that sample matched the expected pattern
//  o_TX_SbMessage      out  4  message to transmit
//  o_ValidOutData      out  1  1-cycle request to TX arbiter
//  o_VAL_Rx_En         out  1  enables valid-lane receive comparator
//  o_VAL_Result        out  1  logged result, 1 = pass; also the result_resp data bit
//  o_VAL_Result_logged out  1  level: o_VAL_Result is valid
//  o_train_error_req   out  1  1-cycle pulse on timeout or protocol violation
//  o_REPAIRVAL_rx_end  out  1  level: responder side complete
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counters 0. Outputs registered, decoded from next state (1-cycle latency).
//  States/transitions (i_REPAIRVAL_en low -> IDLE from every state; takes priority over all else):
//   IDLE           -> WAIT_INIT   when en.
//   WAIT_INIT      -> BUSY_INIT   on msg_valid && msg==1.
//   BUSY_INIT      -> SEND_INIT   when !Busy_SideBand.
//   SEND_INIT      -> RX_PATTERN  on falling_edge_busy. o_TX_SbMessage=2, o_ValidOutData=1 on entry cycle only;
//                     o_TX_SbMessage held until exit.
//   RX_PATTERN     o_VAL_Rx_En=1; -> BUSY_RESULT on msg_valid && msg==3 (result frozen at that cycle).
//   BUSY_RESULT    -> SEND_RESULT when !Busy_SideBand.
//   SEND_RESULT    msg=4, o_VAL_Result carried; -> WAIT_DONE on falling_edge_busy.
//   WAIT_DONE      -> BUSY_DONE on msg_valid && msg==5.
//   BUSY_DONE      -> SEND_DONE when !Busy_SideBand.
//   SEND_DONE      msg=6; -> DONE on falling_edge_busy.
//   DONE           o_REPAIRVAL_rx_end=1 held until en drops.
//   ERROR          o_train_error_req pulses on entry; stays until en drops.
//  Sample window: sample_cnt (8b min, saturating at PATTERN_LEN) and err_cnt (saturating) clear on entry to
//   RX_PATTERN; increment only in RX_PATTERN on i_val_sample_valid; samples beyond PATTERN_LEN ignored.
//  Result: pass = (sample_cnt==PATTERN_LEN) && (err_cnt<=ERR_THRESH), evaluated in the result_req cycle;
//   early result_req (sample_cnt<PATTERN_LEN) logs fail. o_VAL_Result_logged=1 from next cycle until IDLE.
//  Timeout: cycle counter clears on every state change; in WAIT_INIT/RX_PATTERN/WAIT_DONE reaching
//   TIMEOUT_CYC -> ERROR.
//  Protocol violation: msg_valid with an unexpected request code (1,3,5 not expected in current WAIT state/
//   RX_PATTERN) -> ERROR. Codes 2,4,6 (own-initiator traffic) always ignored.
//  Simultaneous: en drop beats message/timeout; msg==3 in the same cycle as a final sample counts the sample.
//  Reset mid-operation: immediate return to reset values; no pending TX request survives.
// TESTING
//  Nominal: init_req; 128 matching samples; result_req; done_req -> TX msgs 2,4,6 each one ValidOutData
//   pulse after busy low; o_VAL_Result=1; rx_end=1.
//  One mismatch, ERR_THRESH=0 -> o_VAL_Result=0, logged=1, flow still completes to DONE.
//  result_req after 100 samples -> o_VAL_Result=0; 140 samples -> counts stop at 128, pass.
//  Busy_SideBand high 20 cycles when init_req arrives -> no ValidOutData until busy low, then exactly one pulse.
//  No init_req for TIMEOUT_CYC cycles -> one train_error pulse, ERROR; done_req in WAIT_INIT -> ERROR.
//  en dropped in RX_PATTERN, and rst asserted in SEND_RESULT -> IDLE, all outputs 0 next cycle/immediately.

Source files
------------

// File: rtl/repairval_partner_responder.sv
// rtl/repairval_partner_responder.sv - responder half of the MBINIT.REPAIRVAL sideband handshake
// Answers init/result/done requests and logs the valid-lane pass/fail result between init and result.
module repairval_partner_responder #(
  parameter int PATTERN_LEN = 128,
  parameter int ERR_THRESH  = 0,
  parameter int TIMEOUT_CYC = 8000
) (
  input  logic       CLK,
  input  logic       rst,
  input  logic       i_REPAIRVAL_en,
  input  logic [3:0] i_Rx_SbMessage,
  input  logic       i_msg_valid,
  input  logic       i_Busy_SideBand,
  input  logic       i_falling_edge_busy,
  input  logic       i_val_sample_valid,
  input  logic       i_val_sample_match,
  output logic [3:0] o_TX_SbMessage,
  output logic       o_ValidOutData,
  output logic       o_VAL_Rx_En,
  output logic       o_VAL_Result,
  output logic       o_VAL_Result_logged,
  output logic       o_train_error_req,
  output logic       o_REPAIRVAL_rx_end
);
  localparam int CW = ($clog2(PATTERN_LEN + 1) > 8) ? $clog2(PATTERN_LEN + 1) : 8;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  localparam logic [3:0] MSG_INIT_REQ    = 4'd1;
  localparam logic [3:0] MSG_INIT_RESP   = 4'd2;
  localparam logic [3:0] MSG_RESULT_REQ  = 4'd3;
  localparam logic [3:0] MSG_RESULT_RESP = 4'd4;
  localparam logic [3:0] MSG_DONE_REQ    = 4'd5;
  localparam logic [3:0] MSG_DONE_RESP   = 4'd6;

  typedef enum logic [3:0] {
    IDLE, WAIT_INIT, BUSY_INIT, SEND_INIT, RX_PATTERN, BUSY_RESULT,
    SEND_RESULT, WAIT_DONE, BUSY_DONE, SEND_DONE, DONE, ERROR
  } state_e;

  state_e        state, next_state;
  logic [CW-1:0] sample_cnt, err_cnt, sample_cnt_nx, err_cnt_nx;
  logic [TW-1:0] timer;
  logic          take_sample, pass_now, timed_out, wait_state;
  logic          is_init_req, is_result_req, is_done_req, any_req;
  logic [3:0]    tx_msg_nx;
  logic          valid_nx, result_nx, logged_nx;

  // err_cnt can never pass sample_cnt, so saturating sample_cnt also bounds err_cnt
  assign take_sample   = (state == RX_PATTERN) && i_val_sample_valid && (int'(sample_cnt) < PATTERN_LEN);
  assign sample_cnt_nx = sample_cnt + CW'(take_sample);
  assign err_cnt_nx    = err_cnt + CW'(take_sample && !i_val_sample_match);
  assign pass_now      = (int'(sample_cnt_nx) == PATTERN_LEN) && (int'(err_cnt_nx) <= ERR_THRESH);

  assign is_init_req   = i_msg_valid && (i_Rx_SbMessage == MSG_INIT_REQ);
  assign is_result_req = i_msg_valid && (i_Rx_SbMessage == MSG_RESULT_REQ);
  assign is_done_req   = i_msg_valid && (i_Rx_SbMessage == MSG_DONE_REQ);
  assign any_req       = is_init_req || is_result_req || is_done_req;
  assign wait_state    = (state == WAIT_INIT) || (state == RX_PATTERN) || (state == WAIT_DONE);
  assign timed_out     = wait_state && (timer == TW'(TIMEOUT_CYC - 1));

  always_comb begin
    next_state = state;
    tx_msg_nx  = 4'd0;
    valid_nx   = 1'b0;
    result_nx  = o_VAL_Result;
    logged_nx  = o_VAL_Result_logged;
    if (!i_REPAIRVAL_en) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:        next_state = WAIT_INIT;
        WAIT_INIT:   if (is_init_req) next_state = BUSY_INIT;
                     else if (any_req || timed_out) next_state = ERROR;
        BUSY_INIT:   if (!i_Busy_SideBand) next_state = SEND_INIT;
        SEND_INIT:   if (i_falling_edge_busy) next_state = RX_PATTERN;
        RX_PATTERN:  if (is_result_req) next_state = BUSY_RESULT;
                     else if (any_req || timed_out) next_state = ERROR;
        BUSY_RESULT: if (!i_Busy_SideBand) next_state = SEND_RESULT;
        SEND_RESULT: if (i_falling_edge_busy) next_state = WAIT_DONE;
        WAIT_DONE:   if (is_done_req) next_state = BUSY_DONE;
                     else if (any_req || timed_out) next_state = ERROR;
        BUSY_DONE:   if (!i_Busy_SideBand) next_state = SEND_DONE;
        SEND_DONE:   if (i_falling_edge_busy) next_state = DONE;
        DONE:        next_state = DONE;
        ERROR:       next_state = ERROR;
        default:     next_state = IDLE;
      endcase
    end

    case (next_state)
      SEND_INIT:   tx_msg_nx = MSG_INIT_RESP;
      SEND_RESULT: tx_msg_nx = MSG_RESULT_RESP;
      SEND_DONE:   tx_msg_nx = MSG_DONE_RESP;
      default:     tx_msg_nx = 4'd0;
    endcase
    valid_nx = (tx_msg_nx != 4'd0) && (next_state != state);

    if (next_state == IDLE) begin
      result_nx = 1'b0;
      logged_nx = 1'b0;
    end else if (state == RX_PATTERN && next_state == BUSY_RESULT) begin
      result_nx = pass_now;
      logged_nx = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state               <= IDLE;
      sample_cnt          <= '0;
      err_cnt             <= '0;
      timer               <= '0;
      o_TX_SbMessage      <= 4'd0;
      o_ValidOutData      <= 1'b0;
      o_VAL_Rx_En         <= 1'b0;
      o_VAL_Result        <= 1'b0;
      o_VAL_Result_logged <= 1'b0;
      o_train_error_req   <= 1'b0;
      o_REPAIRVAL_rx_end  <= 1'b0;
    end else begin
      state               <= next_state;
      o_TX_SbMessage      <= tx_msg_nx;
      o_ValidOutData      <= valid_nx;
      o_VAL_Rx_En         <= (next_state == RX_PATTERN);
      o_VAL_Result        <= result_nx;
      o_VAL_Result_logged <= logged_nx;
      o_train_error_req   <= (next_state == ERROR) && (state != ERROR);
      o_REPAIRVAL_rx_end  <= (next_state == DONE);
      if (next_state != state || !wait_state) timer <= '0;
      else                                    timer <= timer + TW'(1);
      if (next_state == RX_PATTERN && state != RX_PATTERN) begin
        sample_cnt <= '0;
        err_cnt    <= '0;
      end else begin
        sample_cnt <= sample_cnt_nx;
        err_cnt    <= err_cnt_nx;
      end
    end
  end
endmodule

// File: tb/tb_repairval_partner_responder.sv
// tb/tb_repairval_partner_responder.sv - randomized bench for repairval_partner_responder
// Drives directed and random handshakes plus a TX emulator; compares every cycle against a phase model.
module tb_repairval_partner_responder;
  localparam int PLEN = 128;
  localparam int THR  = 0;
  localparam int TOUT = 400;

  logic       CLK = 1'b0;
  logic       rst, en, mv, busy, feb, sv, sm;
  logic [3:0] msg;
  logic [3:0] o_TX_SbMessage;
  logic       o_ValidOutData, o_VAL_Rx_En, o_VAL_Result, o_VAL_Result_logged;
  logic       o_train_error_req, o_REPAIRVAL_rx_end;
  logic [9:0] outs;

  repairval_partner_responder #(.PATTERN_LEN(PLEN), .ERR_THRESH(THR), .TIMEOUT_CYC(TOUT)) dut (
    .CLK(CLK), .rst(rst), .i_REPAIRVAL_en(en), .i_Rx_SbMessage(msg), .i_msg_valid(mv),
    .i_Busy_SideBand(busy), .i_falling_edge_busy(feb), .i_val_sample_valid(sv),
    .i_val_sample_match(sm), .o_TX_SbMessage(o_TX_SbMessage), .o_ValidOutData(o_ValidOutData),
    .o_VAL_Rx_En(o_VAL_Rx_En), .o_VAL_Result(o_VAL_Result), .o_VAL_Result_logged(o_VAL_Result_logged),
    .o_train_error_req(o_train_error_req), .o_REPAIRVAL_rx_end(o_REPAIRVAL_rx_end)
  );

  assign outs = {o_TX_SbMessage, o_ValidOutData, o_VAL_Rx_En, o_VAL_Result,
                 o_VAL_Result_logged, o_train_error_req, o_REPAIRVAL_rx_end};

  always #5 CLK = ~CLK;

  // Model: which handshake we are in, and where within it (awaiting request, awaiting TX, sending)
  typedef enum int {M_IDLE, M_INIT, M_RES, M_DN, M_DONE, M_ERR} stage_t;
  typedef enum int {S_REQ, S_BUSY, S_SEND} sub_t;
  stage_t m_stage, p_stage;
  sub_t   m_sub, p_sub;
  int     m_dwell, m_cnt, m_err;
  bit     m_res, m_logged;

  int n_checks = 0, n_pass = 0, cyc = 0;
  int vod_seen = 0, vod_bad = 0, terr_seen = 0, tx_cnt = 0, hold_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: dut=%0h want=%0h at cycle %0d", name, act, exp, cyc);
  endtask

  function automatic void model_reset();
    m_stage = M_IDLE; p_stage = M_IDLE; m_sub = S_REQ; p_sub = S_REQ;
    m_dwell = 0; m_cnt = 0; m_err = 0; m_res = 0; m_logged = 0;
  endfunction

  function automatic void model_step();
    int want;
    p_stage = m_stage;
    p_sub   = m_sub;
    if (!en) begin
      m_stage = M_IDLE; m_sub = S_REQ;
    end else if (m_stage == M_IDLE) begin
      m_stage = M_INIT; m_sub = S_REQ;
    end else if (m_stage inside {M_INIT, M_RES, M_DN}) begin
      if (m_sub == S_REQ) begin
        want = (m_stage == M_INIT) ? 1 : (m_stage == M_RES) ? 3 : 5;
        if (m_stage == M_RES && sv && m_cnt < PLEN) begin
          m_cnt++;
          if (!sm) m_err++;
        end
        if (mv && int'(msg) == want) begin
          m_sub = S_BUSY;
          if (m_stage == M_RES) begin
            m_res = (m_cnt == PLEN) && (m_err <= THR);
            m_logged = 1;
          end
        end else if (mv && (msg == 4'd1 || msg == 4'd3 || msg == 4'd5)) m_stage = M_ERR;
        else if (m_dwell + 1 >= TOUT) m_stage = M_ERR;
      end else if (m_sub == S_BUSY) begin
        if (!busy) m_sub = S_SEND;
      end else if (feb) begin
        m_sub = S_REQ;
        if (m_stage == M_INIT) begin
          m_stage = M_RES; m_cnt = 0; m_err = 0;
        end else if (m_stage == M_RES) m_stage = M_DN;
        else m_stage = M_DONE;
      end
    end
    if (m_stage == M_IDLE) begin
      m_res = 0; m_logged = 0;
    end
    if (m_stage != p_stage || m_sub != p_sub) m_dwell = 0;
    else m_dwell++;
  endfunction

  function automatic logic [9:0] exp_vec();
    logic [3:0] m;
    logic vod, rxen, terr, fin;
    m = 4'd0;
    if (m_sub == S_SEND) m = (m_stage == M_INIT) ? 4'd2 : (m_stage == M_RES) ? 4'd4 : 4'd6;
    vod  = (m_sub == S_SEND) && !(p_sub == S_SEND && p_stage == m_stage);
    rxen = (m_stage == M_RES) && (m_sub == S_REQ);
    terr = (m_stage == M_ERR) && (p_stage != M_ERR);
    fin  = (m_stage == M_DONE);
    return {m, vod, rxen, m_res, m_logged, terr, fin};
  endfunction

  // One clock: compare at negedge, advance model at posedge, then emulate the sideband TX
  task automatic step();
    @(negedge CLK);
    if (rst) begin
      model_reset();
      check("reset_outputs", 32'(outs), 32'd0);
    end else check("model_outputs", 32'(outs), 32'(exp_vec()));
    @(posedge CLK);
    if (!rst) model_step();
    #1;
    cyc++;
    if (o_ValidOutData) begin
      vod_seen++;
      if (busy) vod_bad++;
    end
    if (o_train_error_req) terr_seen++;
    feb = 0; mv = 0; msg = 4'd0; sv = 0; sm = 0;
    if (tx_cnt > 0) begin
      tx_cnt--;
      if (tx_cnt == 0) begin busy = 0; feb = 1; end
    end else if (o_ValidOutData) begin
      busy = 1; tx_cnt = $urandom_range(2, 6);
    end else if (hold_cnt > 0) begin
      hold_cnt--; busy = (hold_cnt > 0);
    end
  endtask

  function automatic int probe(input int which);
    case (which)
      0:       return int'(o_VAL_Rx_En);
      1:       return int'(o_TX_SbMessage);
      default: return int'(o_REPAIRVAL_rx_end);
    endcase
  endfunction

  task automatic wait_for(input int which, input int val, input string name);
    int k;
    k = 0;
    while (probe(which) != val && k < 300) begin step(); k++; end
    check(name, 32'(probe(which)), 32'(val));
  endtask

  task automatic start_flow(input int hold);
    en = 1; step();
    repeat ($urandom_range(0, 3)) begin
      if ($urandom_range(0, 1) == 1) begin mv = 1; msg = 4'($urandom_range(1, 3) * 2); end
      step();
    end
    if (hold > 0) begin busy = 1; hold_cnt = hold; end
    mv = 1; msg = 4'd1; step();
    wait_for(0, 1, "enter_rx_pattern");
  endtask

  task automatic send_samples(input int n, input int bad, input bit with_last);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) step();
      sv = 1; sm = (i != bad);
      if (with_last && i == n - 1) begin mv = 1; msg = 4'd3; end
      step();
    end
    if (!with_last) begin mv = 1; msg = 4'd3; step(); end
  endtask

  task automatic finish_flow();
    wait_for(1, 4, "send_result_resp");
    wait_for(1, 0, "result_resp_done");
    mv = 1; msg = 4'd5; step();
    wait_for(2, 1, "reach_done");
  endtask

  task automatic full_flow(input int n, input int bad, input int hold, input bit with_last,
                           output bit res, output bit lg, output int vods);
    int v0;
    v0 = vod_seen;
    start_flow(hold);
    send_samples(n, bad, with_last);
    res = o_VAL_Result; lg = o_VAL_Result_logged;
    finish_flow();
    vods = vod_seen - v0;
  endtask

  task automatic end_flow();
    int k;
    en = 0; step();
    k = 0;
    while ((tx_cnt > 0 || hold_cnt > 0) && k < 30) begin step(); k++; end
    step();
  endtask

  initial begin
    bit r, l;
    int v, t0, b0, n, bad;
    rst = 1; en = 0; mv = 0; msg = 4'd0; busy = 0; feb = 0; sv = 0; sm = 0;
    model_reset();
    repeat (3) step();
    check("reset_state", 32'(outs), 32'd0);
    rst = 0; step();

    full_flow(PLEN, -1, 0, 1, r, l, v);
    check("nominal_result", 32'(r), 32'd1);
    check("nominal_logged", 32'(l), 32'd1);
    check("nominal_vod_pulses", 32'(v), 32'd3);
    check("nominal_rx_end", 32'(o_REPAIRVAL_rx_end), 32'd1);
    end_flow();

    full_flow(PLEN, 50, 0, 0, r, l, v);
    check("one_mismatch_result", 32'(r), 32'd0);
    check("one_mismatch_logged", 32'(l), 32'd1);
    check("one_mismatch_rx_end", 32'(o_REPAIRVAL_rx_end), 32'd1);
    end_flow();

    full_flow(100, -1, 0, 0, r, l, v);
    check("early_result_fail", 32'(r), 32'd0);
    end_flow();

    full_flow(140, -1, 0, 0, r, l, v);
    check("extra_samples_pass", 32'(r), 32'd1);
    end_flow();

    b0 = vod_bad;
    full_flow(PLEN, -1, 20, 0, r, l, v);
    check("busy_hold_vod_pulses", 32'(v), 32'd3);
    check("busy_hold_no_vod_while_busy", 32'(vod_bad - b0), 32'd0);
    end_flow();

    t0 = terr_seen;
    en = 1;
    repeat (TOUT + 10) step();
    check("timeout_error_pulses", 32'(terr_seen - t0), 32'd1);
    end_flow();

    en = 1; step();
    t0 = terr_seen;
    mv = 1; msg = 4'd5; step(); step();
    check("done_req_in_wait_init", 32'(terr_seen - t0), 32'd1);
    end_flow();

    start_flow(0);
    for (int i = 0; i < 10; i++) begin sv = 1; sm = 1; step(); end
    en = 0; step();
    check("en_drop_outputs_zero", 32'(outs), 32'd0);
    end_flow();

    start_flow(0);
    send_samples(PLEN, -1, 0);
    wait_for(1, 4, "reach_send_result");
    rst = 1; #1;
    check("rst_async_outputs_zero", 32'(outs), 32'd0);
    tx_cnt = 0; hold_cnt = 0; busy = 0; en = 0;
    step(); step();
    rst = 0; step();

    for (int it = 0; it < 25; it++) begin
      n   = $urandom_range(96, 140);
      bad = ($urandom_range(0, 1) == 1) ? -1 : $urandom_range(0, n - 1);
      full_flow(n, bad, ($urandom_range(0, 2) == 0) ? $urandom_range(1, 8) : 0,
                1'($urandom_range(0, 1)), r, l, v);
      check("random_flow_result", 32'(r), 32'((n >= PLEN) && (bad < 0 || bad >= PLEN)));
      check("random_flow_vod_pulses", 32'(v), 32'd3);
      end_flow();
    end

    for (int c = 0; c < 3000; c++) begin
      en = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 29) == 0) begin mv = 1; msg = 4'($urandom_range(1, 6)); end
      sv = ($urandom_range(0, 3) != 0);
      sm = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 99) == 0 && tx_cnt == 0 && hold_cnt == 0) begin
        busy = 1; hold_cnt = $urandom_range(1, 10);
      end
      if ($urandom_range(0, 499) == 0) begin
        rst = 1; step();
        tx_cnt = 0; hold_cnt = 0; busy = 0; rst = 0;
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
